// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix multiply engine.
package matmul_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_STORE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic WR_SEL_A = 1'b0;
  localparam logic WR_SEL_B = 1'b1;

  // Ceiling log2, never below 1 so every counter/address has at least one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/matmul_engine_mac.sv
// Multiply-accumulate slice: one product per cycle into a wrapping accumulator.
module mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  prod
);

  localparam int PW = 2 * DATA_W;

  logic [PW-1:0]    a_x, b_x, prod_full;
  logic             ext;
  logic [ACC_W-1:0] acc_q, acc_d;

  // Operands extended to full product width; the low PW bits of the
  // product are then exact for both signed and unsigned operands.
  always_comb begin
    if (SIGNED) begin
      a_x = {{DATA_W{a[DATA_W-1]}}, a};
      b_x = {{DATA_W{b[DATA_W-1]}}, b};
    end else begin
      a_x = {{DATA_W{1'b0}}, a};
      b_x = {{DATA_W{1'b0}}, b};
    end
    prod_full = a_x * b_x;
    ext       = SIGNED & prod_full[PW-1];
  end

  if (ACC_W > PW) begin : g_ext
    assign prod = {{(ACC_W - PW){ext}}, prod_full};
  end else begin : g_trunc
    assign prod = prod_full[ACC_W-1:0];
  end

  // Clear has priority so a new element never sees the previous sum.
  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q + prod;
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/matmul_engine.sv
// MxK * KxN integer matrix multiplier with on-chip A/B/R storage.
// One R element takes K MAC cycles plus one STORE cycle.
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int M      = 2,
  parameter int K      = 2,
  parameter int N      = 2,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2 * DATA_W + $clog2(K + 1),
  parameter int SIGNED = 0,
  parameter int AW     = clog2(max2(M * K, K * N)),
  parameter int RW     = clog2(M * N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [RW-1:0]     rd_addr,
  output logic [ACC_W-1:0]  rd_data
);

  localparam int AAW = clog2(M * K);
  localparam int BAW = clog2(K * N);
  localparam int IW  = clog2(M);
  localparam int JW  = clog2(N);
  localparam int KW  = clog2(K);

  state_e state_q, state_d;
  logic [IW-1:0]     i_q, i_d;
  logic [JW-1:0]     j_q, j_d;
  logic [KW-1:0]     k_q, k_d;
  logic              busy_q, busy_d, done_q, done_d, wr_err_q, wr_err_d;
  logic [ACC_W-1:0]  rd_data_q, rd_data_d;

  logic [DATA_W-1:0] a_mem [M*K];
  logic [DATA_W-1:0] b_mem [K*N];
  logic [ACC_W-1:0]  r_mem [M*N];
  logic [DATA_W-1:0] a_rd_q, b_rd_q;

  logic [AAW-1:0]    a_raddr;
  logic [BAW-1:0]    b_raddr;
  logic [RW-1:0]     r_waddr;
  logic              a_we, b_we, r_we, mac_clr, mac_en;
  logic              last_i, last_j, last_k;
  logic [ACC_W-1:0]  acc, prod;

  assign last_i = (int'(i_q) == M - 1);
  assign last_j = (int'(j_q) == N - 1);
  assign last_k = (int'(k_q) == K - 1);

  mac_unit #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W),
    .SIGNED(SIGNED != 0)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (mac_clr),
    .en   (mac_en),
    .a    (a_rd_q),
    .b    (b_rd_q),
    .acc  (acc),
    .prod (prod)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: K MAC cycles per element, then one STORE; DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_MAC;
      S_MAC:   if (last_k) state_d = S_STORE;
      S_STORE: state_d = (last_i && last_j) ? S_DONE : S_MAC;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: MAC control, RAM addresses and registered busy/done.
  always_comb begin
    mac_clr = (state_q == S_MAC) && (k_q == '0);
    mac_en  = (state_q == S_MAC) && (k_q != '0);
    r_we    = (state_q == S_STORE);
    a_raddr = AAW'(int'(i_q) * K + int'(k_q));
    b_raddr = BAW'(int'(k_q) * N + int'(j_q));
    r_waddr = RW'(int'(i_q) * N + int'(j_q));
    busy_d  = (state_d == S_MAC) || (state_d == S_STORE);
    done_d  = (state_d == S_DONE);
  end

  // Element counters: k walks the dot product, j then i walk R row-major.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    case (state_q)
      S_IDLE: begin
        i_d = '0;
        j_d = '0;
        k_d = '0;
      end
      S_MAC: k_d = last_k ? '0 : k_q + KW'(1);
      S_STORE: begin
        if (last_j) begin
          j_d = '0;
          i_d = last_i ? '0 : i_q + IW'(1);
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      default: ;
    endcase
  end

  // Host writes: rejected while running or when outside the selected matrix.
  always_comb begin
    a_we     = 1'b0;
    b_we     = 1'b0;
    wr_err_d = 1'b0;
    if (wr_en) begin
      if (busy_q)                          wr_err_d = 1'b1;
      else if (wr_sel == WR_SEL_A) begin
        if (int'(wr_addr) < M * K)         a_we     = 1'b1;
        else                               wr_err_d = 1'b1;
      end else if (wr_sel == WR_SEL_B) begin
        if (int'(wr_addr) < K * N)         b_we     = 1'b1;
        else                               wr_err_d = 1'b1;
      end
    end
  end

  // Host read port; addresses past the end of R read as zero.
  always_comb begin
    rd_data_d = (int'(rd_addr) < M * N) ? r_mem[rd_addr] : '0;
  end

  // Operand/result RAMs with synchronous reads; contents survive reset.
  always_ff @(posedge clk) begin
    if (a_we) a_mem[AAW'(wr_addr)] <= wr_data;
    if (b_we) b_mem[BAW'(wr_addr)] <= wr_data;
    if (r_we) r_mem[r_waddr]       <= acc + prod;
    a_rd_q <= a_mem[a_raddr];
    b_rd_q <= b_mem[b_raddr];
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_err_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_err_q  <= wr_err_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_err  = wr_err_q;
  assign rd_data = rd_data_q;

endmodule
